ms_alarm: RTL and testbench
===========================

MS_ALARM -- requirements
Module: ms_alarm

Interface
REQ-001 SHALL have parameter W, default 32, width of ms_count, duration and remaining-time values.
REQ-002 SHALL have port clk  input  1  system clock, 16 MHz; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ms_count  input  W  free-running millisecond count, +1 per ms, wraps modulo 2^W.
REQ-005 SHALL have port wr_en  input  1  one-cycle write strobe.
REQ-006 SHALL have port wr_addr  input  1  0 = ARM (wr_data is duration in ms); 1 = CTRL (bit0 cancel, bit1 ack).
REQ-007 SHALL have port wr_data  input  W  write data.
REQ-008 SHALL have port rd_data  output  W  remaining ms until expiry; 0 when not ARMED.
REQ-009 SHALL have port armed  output  1  high in state ARMED.
REQ-010 SHALL have port irq  output  1  high in state FIRED; sticky until ack, cancel or re-arm.

Function
REQ-011 SHALL implement states IDLE, ARMED and FIRED.
REQ-012 ARM write, any state: deadline <= ms_count + min(wr_data, 2^(W-1)-1), modulo 2^W; next state ARMED; irq cleared.
REQ-013 Duration clamp SHALL keep the wrap-safe comparison valid.
REQ-014 Expiry SHALL be defined as MSB of (ms_count - deadline) mod 2^W equal to 0, i.e. ms_count at or past deadline, wrap-safe.
REQ-015 ARMED with expiry true and no write that cycle: next state FIRED; irq high the cycle after ms_count first equals deadline (1-cycle latency).
REQ-016 Duration 0: irq SHALL assert the second cycle after the ARM write (ARMED for exactly one cycle).
REQ-017 CTRL write with bit0=1 (cancel), any state: next state IDLE.
REQ-018 CTRL write with bit1=1 (ack) in FIRED: next state IDLE.
REQ-019 Ack in IDLE or ARMED SHALL have no effect.
REQ-020 Write in same cycle as expiry: the write SHALL take priority over expiry.
REQ-021 ARM written while ARMED SHALL replace the deadline (no fire for the old deadline).
REQ-022 CTRL write with bits 0 and 1 both set SHALL result in IDLE.
REQ-023 CTRL write with both bits clear SHALL have no effect.
REQ-024 rd_data in ARMED SHALL be (deadline - ms_count) mod 2^W, forced to 0 when its MSB is set.
REQ-025 rd_data in IDLE and FIRED SHALL be 0.
REQ-026 rd_data SHALL be combinational from the registered deadline and ms_count.
REQ-027 ms_count jumps of any size SHALL be tolerated; expiry is evaluated on the present value only.

Reset
REQ-028 reset high SHALL force state IDLE, deadline 0, armed 0, irq 0, rd_data 0 on the next edge.
REQ-029 reset SHALL override any same-cycle write.
REQ-030 reset mid-ARMED SHALL cancel the alarm with no irq.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ARMED, FIRED), the address constants ADDR_ARM=0 and ADDR_CTRL=1, and the CTRL bit indices CANCEL=0 and ACK=1.
REQ-032 No sub-module SHALL be used; the block is a single FSM plus deadline register and subtractors; expected size is about 150 lines.

Verification
REQ-033 Basic fire: ms_count=100, ARM 5 -> rd_data=5; rd_data=2 at ms_count=103; irq rises the cycle after ms_count=105, armed falls with it.
REQ-034 Wrap: ms_count=0xFFFFFFFE, ARM 4 -> deadline 0x00000002; no irq at ms_count=0xFFFFFFFF or 0x1; irq after ms_count=0x2.
REQ-035 Zero and clamp:
- ARM 0 -> irq asserts 2 cycles after the write.
- ARM 0xFFFFFFFF at ms_count=0 -> rd_data=0x7FFFFFFF and no immediate fire.
REQ-036 Priority: CTRL cancel in the same cycle ms_count reaches deadline -> IDLE and irq never asserts; ARM 10 during FIRED -> irq clears and armed=1.
REQ-037 Ack and reset:
- CTRL ack in FIRED -> irq 0 next cycle.
- Ack in ARMED -> armed stays 1.
- reset pulse while ARMED with 3 ms remaining -> all outputs 0 and no later irq.

Source files
------------

// File: rtl/ms_alarm_pkg.sv
// Shared definitions for the millisecond alarm.
//   state_t   : alarm FSM state (IDLE, ARMED, FIRED)
//   ADDR_ARM  : write address for arming; wr_data is the duration in ms
//   ADDR_CTRL : write address for control; bit CANCEL and bit ACK
package ms_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam logic ADDR_ARM  = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int CANCEL = 0;
    localparam int ACK    = 1;

endpackage

// File: rtl/ms_alarm.sv
// Millisecond alarm: arm with a duration, fires an interrupt when the
// free-running millisecond counter reaches the computed deadline.
//
// Ports
//   clk      : system clock, all logic on its rising edge
//   reset    : synchronous, active-high reset
//   ms_count : free-running millisecond counter (wraps modulo 2^W)
//   wr_en    : one-cycle write strobe
//   wr_addr  : ADDR_ARM (duration) or ADDR_CTRL (cancel / ack bits)
//   wr_data  : write data
//   rd_data  : remaining ms until expiry while ARMED, otherwise 0
//   armed    : high while ARMED
//   irq      : high while FIRED; sticky until ack, cancel or re-arm
//
// Write handshake: a write is accepted on every clock edge where wr_en is
// high; there is no back-pressure. A write always beats a same-cycle expiry.
module ms_alarm
    import ms_alarm_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] ms_count,
    input  logic         wr_en,
    input  logic         wr_addr,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         armed,
    output logic         irq
);

    // Largest duration that keeps the signed (MSB-based) distance
    // comparison between ms_count and deadline unambiguous.
    localparam logic [W-1:0] MAX_DUR = {1'b0, {(W-1){1'b1}}};

    state_t       state_q, state_d;
    logic [W-1:0] deadline_q, deadline_d;

    logic [W-1:0] duration;
    logic [W-1:0] elapsed;
    logic [W-1:0] remain;
    logic         expired;

    // Any value with the MSB set is at least 2^(W-1), so clamp it.
    assign duration = wr_data[W-1] ? MAX_DUR : wr_data;

    // Wrap-safe: ms_count is at or past deadline when the modular
    // difference is "non-negative" (MSB clear).
    assign elapsed = ms_count - deadline_q;
    assign expired = ~elapsed[W-1];

    assign remain  = deadline_q - ms_count;

    always_comb begin
        state_d    = state_q;
        deadline_d = deadline_q;
        if (wr_en) begin
            if (wr_addr == ADDR_ARM) begin
                state_d    = ARMED;
                deadline_d = ms_count + duration;
            end else begin
                if (wr_data[CANCEL]) begin
                    state_d = IDLE;
                end else if (wr_data[ACK] && (state_q == FIRED)) begin
                    state_d = IDLE;
                end
            end
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ARMED:   state_d = expired ? FIRED : ARMED;
                FIRED:   state_d = FIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            deadline_q <= '0;
        end else begin
            state_q    <= state_d;
            deadline_q <= deadline_d;
        end
    end

    assign armed = (state_q == ARMED);
    assign irq   = (state_q == FIRED);

    // Once ms_count passes the deadline the difference goes "negative";
    // report 0 rather than a huge wrapped value.
    assign rd_data = (armed && !remain[W-1]) ? remain : '0;

endmodule

// File: tb/tb_ms_alarm.sv
`timescale 1ns/1ps
module tb_ms_alarm;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] ms_count;
    logic         wr_en;
    logic         wr_addr;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         armed;
    logic         irq;

    int errors = 0;
    int checks = 0;

    ms_alarm #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ms_count (ms_count),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .armed    (armed),
        .irq      (irq)
    );

    // 16 MHz clock
    initial clk = 1'b0;
    always #31.25 clk = ~clk;

    // One clock edge; returns 1 ns after it so outputs have settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic addr, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        cyc();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic a, input logic i, input logic [W-1:0] r);
        check({tag, ".armed"}, {31'd0, armed}, {31'd0, a});
        check({tag, ".irq"},   {31'd0, irq},   {31'd0, i});
        check({tag, ".rd"},    rd_data,        r);
    endtask

    initial begin
        reset    = 1'b1;
        ms_count = '0;
        wr_en    = 1'b0;
        wr_addr  = 1'b0;
        wr_data  = '0;
        cyc();
        cyc();
        reset = 1'b0;
        check3("reset", 1'b0, 1'b0, 32'd0);

        // Basic fire
        ms_count = 32'd100;
        wr(1'b0, 32'd5);
        check3("basic_arm", 1'b1, 1'b0, 32'd5);
        ms_count = 32'd103;
        #1;
        check3("basic_103", 1'b1, 1'b0, 32'd2);
        cyc();
        ms_count = 32'd104;
        cyc();
        check3("basic_104", 1'b1, 1'b0, 32'd1);
        ms_count = 32'd105;
        #1;
        check3("basic_105_pre", 1'b1, 1'b0, 32'd0);
        cyc();
        check3("basic_fired", 1'b0, 1'b1, 32'd0);
        cyc();
        check3("basic_sticky", 1'b0, 1'b1, 32'd0);

        // Ack in FIRED
        wr(1'b1, 32'd2);
        check3("ack_fired", 1'b0, 1'b0, 32'd0);

        // Wrap
        ms_count = 32'hFFFF_FFFE;
        wr(1'b0, 32'd4);
        check3("wrap_arm", 1'b1, 1'b0, 32'd4);
        ms_count = 32'hFFFF_FFFF;
        cyc();
        check3("wrap_ffff", 1'b1, 1'b0, 32'd3);
        ms_count = 32'h0000_0001;
        cyc();
        check3("wrap_1", 1'b1, 1'b0, 32'd1);
        ms_count = 32'h0000_0002;
        cyc();
        check3("wrap_fire", 1'b0, 1'b1, 32'd0);

        // Re-arm during FIRED
        ms_count = 32'd200;
        wr(1'b0, 32'd10);
        check3("rearm_fired", 1'b1, 1'b0, 32'd10);

        // Ack and no-op control while ARMED
        wr(1'b1, 32'd2);
        check3("ack_armed", 1'b1, 1'b0, 32'd10);
        wr(1'b1, 32'd0);
        check3("ctrl_noop", 1'b1, 1'b0, 32'd10);

        // Cancel in the same cycle ms_count reaches the deadline
        ms_count = 32'd210;
        wr(1'b1, 32'd1);
        check3("cancel_at_dl", 1'b0, 1'b0, 32'd0);
        cyc();
        cyc();
        check3("cancel_no_irq", 1'b0, 1'b0, 32'd0);

        // Zero duration
        ms_count = 32'd300;
        wr(1'b0, 32'd0);
        check3("zero_arm", 1'b1, 1'b0, 32'd0);
        cyc();
        check3("zero_fire", 1'b0, 1'b1, 32'd0);

        // Cancel + ack together from FIRED
        wr(1'b1, 32'd3);
        check3("cancel_ack", 1'b0, 1'b0, 32'd0);

        // Clamp
        ms_count = 32'd0;
        wr(1'b0, 32'hFFFF_FFFF);
        check3("clamp_arm", 1'b1, 1'b0, 32'h7FFF_FFFF);
        cyc();
        check3("clamp_hold", 1'b1, 1'b0, 32'h7FFF_FFFF);

        // Re-arm while ARMED replaces the deadline
        ms_count = 32'd1000;
        wr(1'b0, 32'd3);
        wr(1'b0, 32'd50);
        ms_count = 32'd1003;
        cyc();
        check3("replace_old_dl", 1'b1, 1'b0, 32'd47);

        // Reset mid-ARMED, with a same-cycle ARM write that must lose
        ms_count = 32'd1047;
        #1;
        check3("pre_reset", 1'b1, 1'b0, 32'd3);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 1'b0;
        wr_data = 32'd20;
        cyc();
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        check3("reset_armed", 1'b0, 1'b0, 32'd0);
        ms_count = 32'd1050;
        cyc();
        cyc();
        check3("reset_no_irq", 1'b0, 1'b0, 32'd0);

        // Large jump of ms_count past the deadline
        ms_count = 32'd2000;
        wr(1'b0, 32'd10);
        ms_count = 32'd5000;
        #1;
        check3("jump_pre", 1'b1, 1'b0, 32'd0);
        cyc();
        check3("jump_fire", 1'b0, 1'b1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
